as_pipeline_stall_ctrl: RTL
===========================

// Module: as_pipeline_stall_ctrl
// PURPOSE
//  Stall/bubble controller for the 5-stage RV64I pipeline; it complements the forwarding unit.
//  Forwarding covers hazards the bypass can resolve. This block covers the two it cannot:
//  - load-use: a load in EX feeds the instruction in ID; one bubble is inserted.
//  - data-memory wait: a MEM-stage access without a same-cycle ack freezes the whole pipe.
//  It drives the pipeline-register write enables and flushes, and counts stall cycles.
// PARAMETERS
//  REG_ADDR_W  5    register index width
//  CNT_W       32   stall_cnt_o width (saturating)
//  MAX_WAIT    255  consecutive memory-wait cycles before timeout (>=1)
// PORTS
//  clk_i            in   1           clock, rising edge
//  rst_n_i          in   1           asynchronous reset, active low
//  id_ex_mem_rd_i   in   1           instruction in EX is a load
//  id_ex_reg_rd_i   in   REG_ADDR_W  destination register of instruction in EX
//  if_id_reg_rs1_i  in   REG_ADDR_W  rs1 of instruction in ID
//  if_id_reg_rs2_i  in   REG_ADDR_W  rs2 of instruction in ID
//  if_id_rs1_used_i in   1           ID instruction actually reads rs1
//  if_id_rs2_used_i in   1           ID instruction actually reads rs2
//  ex_mem_mem_req_i in   1           MEM stage issues a load/store this cycle
//  dmem_ack_i       in   1           data memory completes the request this cycle
//  pc_wr_o          out  1           PC update enable
//  if_id_wr_o       out  1           IF/ID register write enable
//  id_ex_wr_o       out  1           ID/EX register write enable
//  id_ex_flush_o    out  1           load NOP (bubble) into ID/EX
//  ex_mem_wr_o      out  1           EX/MEM register write enable
//  mem_wb_flush_o   out  1           load NOP into MEM/WB
//  stall_cnt_o      out  CNT_W       total stall cycles, saturating
//  timeout_o        out  1           sticky memory-timeout flag
// BEHAVIOUR
//  - Load-use hazard (combinational), lu = all of:
//    - id_ex_mem_rd_i
//    - id_ex_reg_rd_i != 0
//    - (rs1_used && rs1 == rd) || (rs2_used && rs2 == rd)
//  - Freeze (combinational): (state == RUN && ex_mem_mem_req_i && !dmem_ack_i)
//    || (state == MEM_WAIT && !dmem_ack_i) || state == ERR.
//  - Outputs are Mealy and take effect in the same cycle:
//    - freeze: pc_wr = if_id_wr = id_ex_wr = ex_mem_wr = 0; mem_wb_flush = 1; id_ex_flush = 0.
//    - else lu && state != LU_STALL: pc_wr = if_id_wr = 0; id_ex_wr = 1; id_ex_flush = 1;
//      ex_mem_wr = 1; mem_wb_flush = 0.
//    - else: all write enables 1, both flushes 0.
//  - Freeze has priority over lu; the load-use bubble follows in the first unfrozen cycle.
//  - FSM states RUN, LU_STALL, MEM_WAIT, ERR; reset state RUN.
//    - RUN -> MEM_WAIT when freeze; RUN -> LU_STALL on a lu bubble.
//    - LU_STALL: lu is ignored here (at most one bubble per load). Next state is MEM_WAIT if
//      req && !ack, else RUN.
//    - MEM_WAIT -> RUN on dmem_ack_i. The ack cycle itself is not frozen.
//  - wait_cnt increments on each freeze cycle and clears on any unfrozen cycle.
//    - A freeze cycle with wait_cnt == MAX_WAIT-1 moves to ERR and sets timeout_o next cycle.
//    - ERR holds freeze and timeout_o until reset; dmem_ack_i is ignored.
//  - stall_cnt_o increments by 1 on every freeze or bubble cycle and saturates at all-ones.
//  - Reset (async, any state, mid-wait included): state RUN, wait_cnt 0, stall_cnt_o 0,
//    timeout_o 0.
//    - While rst_n_i is low: pc_wr = if_id_wr = id_ex_wr = ex_mem_wr = 0; id_ex_flush = 1;
//      mem_wb_flush = 1.
// TESTING
//  - Load-use: EX ld x5, ID add x6,x5,x7 (rs1 used). Required:
//    - exactly 1 cycle with pc_wr = 0, if_id_wr = 0, id_ex_flush = 1;
//    - next cycle all enables 1;
//    - stall_cnt_o = 1.
//  - No false stall, all 0 stall cycles:
//    - ld x0 with rs1 = 0;
//    - rs2 match with rs2_used = 0;
//    - match but id_ex_mem_rd_i = 0.
//  - Memory wait: req at cycle N, ack at N+3. Required:
//    - freeze in N, N+1, N+2; unfrozen at N+3; back in RUN;
//    - stall_cnt_o += 3.
//  - Simultaneous: freeze while lu is true. Required:
//    - id_ex_flush = 0 during freeze;
//    - one bubble in the cycle after ack; then normal flow.
//  - Timeout, MAX_WAIT = 4, req held, never acked. Required:
//    - freeze in cycles 0..3; timeout_o = 1 from cycle 4;
//    - freeze persists even if ack arrives later.
//  - Reset mid MEM_WAIT: rst_n_i low for 1 cycle. Required:
//    - reset output values immediately; after release state RUN;
//    - stall_cnt_o = 0, timeout_o = 0.

Source files
------------

// File: rtl/as_pipeline_stall_ctrl.sv
// Stall/bubble controller for the 5-stage RV64I pipeline.
// Handles the two hazards the bypass network cannot hide: load-use (one
// bubble into ID/EX) and data-memory wait (whole-pipe freeze), with a
// consecutive-wait watchdog and a saturating stall-cycle counter.
module as_pipeline_stall_ctrl #(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned MAX_WAIT   = 255
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  id_ex_mem_rd_i,
    input  logic [REG_ADDR_W-1:0] id_ex_reg_rd_i,
    input  logic [REG_ADDR_W-1:0] if_id_reg_rs1_i,
    input  logic [REG_ADDR_W-1:0] if_id_reg_rs2_i,
    input  logic                  if_id_rs1_used_i,
    input  logic                  if_id_rs2_used_i,
    input  logic                  ex_mem_mem_req_i,
    input  logic                  dmem_ack_i,
    output logic                  pc_wr_o,
    output logic                  if_id_wr_o,
    output logic                  id_ex_wr_o,
    output logic                  id_ex_flush_o,
    output logic                  ex_mem_wr_o,
    output logic                  mem_wb_flush_o,
    output logic [CNT_W-1:0]      stall_cnt_o,
    output logic                  timeout_o
);

    // Wait counter only ever holds 0 .. MAX_WAIT-1.
    localparam int unsigned WAIT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_LU_STALL,
        ST_MEM_WAIT,
        ST_ERR
    } state_e;

    state_e              state_q;
    logic [WAIT_W-1:0]   wait_cnt_q;
    logic [CNT_W-1:0]    stall_cnt_q;
    logic                timeout_q;

    logic                rs1_hit;
    logic                rs2_hit;
    logic                load_use;
    logic                freeze;
    logic                bubble;
    logic                wait_last;
    logic                mem_pending;

    // Hazard detection and freeze/bubble decision for the current cycle.
    always_comb begin
        rs1_hit     = if_id_rs1_used_i && (if_id_reg_rs1_i == id_ex_reg_rd_i);
        rs2_hit     = if_id_rs2_used_i && (if_id_reg_rs2_i == id_ex_reg_rd_i);
        load_use    = id_ex_mem_rd_i && (id_ex_reg_rd_i != '0) && (rs1_hit || rs2_hit);
        mem_pending = ex_mem_mem_req_i && !dmem_ack_i;
        freeze      = ((state_q == ST_RUN) && mem_pending)
                   || ((state_q == ST_MEM_WAIT) && !dmem_ack_i)
                   || (state_q == ST_ERR);
        // Freeze wins; a pending load-use bubble is taken on the first unfrozen cycle.
        bubble      = !freeze && load_use && (state_q != ST_LU_STALL);
        wait_last   = (wait_cnt_q == WAIT_W'(MAX_WAIT - 1));
    end

    // Controller state, wait watchdog, stall counter and sticky timeout.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= ST_RUN;
            wait_cnt_q  <= '0;
            stall_cnt_q <= '0;
            timeout_q   <= 1'b0;
        end else begin
            if ((freeze || bubble) && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end

            if (state_q == ST_ERR) begin
                state_q <= ST_ERR;
            end else if (freeze) begin
                if (wait_last) begin
                    state_q   <= ST_ERR;
                    timeout_q <= 1'b1;
                end else begin
                    state_q    <= ST_MEM_WAIT;
                    wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
                end
            end else begin
                wait_cnt_q <= '0;
                // A bubble taken in the ack cycle of a wait still needs LU_STALL
                // so the held ID instruction is not bubbled a second time.
                if (bubble) begin
                    state_q <= ST_LU_STALL;
                end else if ((state_q == ST_LU_STALL) && mem_pending) begin
                    state_q <= ST_MEM_WAIT;
                end else begin
                    state_q <= ST_RUN;
                end
            end
        end
    end

    // Mealy pipeline-register controls; reset forces a safe held/flushed pipe.
    always_comb begin
        pc_wr_o        = 1'b1;
        if_id_wr_o     = 1'b1;
        id_ex_wr_o     = 1'b1;
        id_ex_flush_o  = 1'b0;
        ex_mem_wr_o    = 1'b1;
        mem_wb_flush_o = 1'b0;
        if (!rst_n_i) begin
            pc_wr_o        = 1'b0;
            if_id_wr_o     = 1'b0;
            id_ex_wr_o     = 1'b0;
            id_ex_flush_o  = 1'b1;
            ex_mem_wr_o    = 1'b0;
            mem_wb_flush_o = 1'b1;
        end else if (freeze) begin
            pc_wr_o        = 1'b0;
            if_id_wr_o     = 1'b0;
            id_ex_wr_o     = 1'b0;
            ex_mem_wr_o    = 1'b0;
            mem_wb_flush_o = 1'b1;
        end else if (bubble) begin
            pc_wr_o        = 1'b0;
            if_id_wr_o     = 1'b0;
            id_ex_flush_o  = 1'b1;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign timeout_o   = timeout_q;

endmodule
